// File: rtl/tank_pkg.sv
// Shared types and default constants for the tank level monitor.
package tank_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2
  } alarm_t;

  localparam int DEF_LEVEL_W     = 9;
  localparam int DEF_CAPACITY    = 100;
  localparam int DEF_NUM_BANDS   = 10;
  localparam int DEF_RESET_LEVEL = 100;
  localparam int DEF_FILL_RATE   = 2;
  localparam int DEF_DRAIN_RATE  = 1;
  localparam int DEF_LOW_TH      = 20;
  localparam int DEF_HIGH_TH     = 90;
  localparam int DEF_HYST        = 5;
  localparam int DEF_DRY_CYCLES  = 8;

endpackage

// File: rtl/level_thermo_enc.sv
// Thermometer encoder: band k is lit once the level reaches (k+1)*STEP.
module level_thermo_enc
  import tank_pkg::*;
#(
  parameter int LEVEL_W   = DEF_LEVEL_W,
  parameter int CAPACITY  = DEF_CAPACITY,
  parameter int NUM_BANDS = DEF_NUM_BANDS
) (
  input  logic [LEVEL_W-1:0]   level,
  output logic [NUM_BANDS-1:0] sensor_out
);

  localparam int STEP = CAPACITY / NUM_BANDS;

  // Inclusive compare so a level sitting exactly on a boundary lights that band.
  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
    localparam logic [LEVEL_W-1:0] BAND_TH = LEVEL_W'((k + 1) * STEP);
    assign sensor_out[k] = (level >= BAND_TH);
  end

endmodule

// File: rtl/tank_level_monitor.sv
// Tank level integrator with clamping, hysteretic alarm FSM and a latched
// dry-pump fault that interlocks the pump.
module tank_level_monitor
  import tank_pkg::*;
#(
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int NUM_BANDS   = DEF_NUM_BANDS,
  parameter int RESET_LEVEL = DEF_RESET_LEVEL,
  parameter int FILL_RATE   = DEF_FILL_RATE,
  parameter int DRAIN_RATE  = DEF_DRAIN_RATE,
  parameter int LOW_TH      = DEF_LOW_TH,
  parameter int HIGH_TH     = DEF_HIGH_TH,
  parameter int HYST        = DEF_HYST,
  parameter int DRY_CYCLES  = DEF_DRY_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pump_activated,
  input  logic                 valve_open,
  input  logic                 fault_clr,
  output logic [LEVEL_W-1:0]   level,
  output logic [NUM_BANDS-1:0] sensor_out,
  output logic [1:0]           alarm_state,
  output logic                 low_alarm,
  output logic                 high_alarm,
  output logic                 dry_fault,
  output logic                 overflow
);

  localparam int SW = LEVEL_W + 2;
  localparam int CW = $clog2(DRY_CYCLES + 1);

  localparam logic signed [SW-1:0] FILL_S  = SW'(FILL_RATE);
  localparam logic signed [SW-1:0] DRAIN_S = SW'(DRAIN_RATE);
  localparam logic signed [SW-1:0] CAP_S   = SW'(CAPACITY);

  localparam logic [LEVEL_W-1:0] CAP_L     = LEVEL_W'(CAPACITY);
  localparam logic [LEVEL_W-1:0] RESET_L   = LEVEL_W'(RESET_LEVEL);
  localparam logic [LEVEL_W-1:0] LOW_ON    = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0] LOW_OFF   = LEVEL_W'(LOW_TH + HYST);
  localparam logic [LEVEL_W-1:0] HIGH_ON   = LEVEL_W'(HIGH_TH);
  localparam logic [LEVEL_W-1:0] HIGH_OFF  = LEVEL_W'(HIGH_TH - HYST);
  localparam logic [CW-1:0]      DRY_LIMIT = CW'(DRY_CYCLES);

  alarm_t                state;
  logic [CW-1:0]         dry_cnt;
  logic                  pump_eff;
  logic signed [SW-1:0]  raw;
  logic [LEVEL_W-1:0]    level_next;

  assign pump_eff = pump_activated & ~dry_fault;

  // Two guard bits keep the unclamped sum exact in both directions.
  always_comb begin
    raw = $signed({2'b00, level})
        + (valve_open ? FILL_S  : '0)
        - (pump_eff   ? DRAIN_S : '0);
    if (raw < 0)
      level_next = '0;
    else if (raw > CAP_S)
      level_next = CAP_L;
    else
      level_next = raw[LEVEL_W-1:0];
  end

  // NOTE: every register here uses <= so all state samples pre-edge values;
  // the FSM therefore sees the old level and lags it by exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level     <= RESET_L;
      overflow  <= 1'b0;
      state     <= NORMAL;
      dry_cnt   <= '0;
      dry_fault <= 1'b0;
    end else begin
      level    <= level_next;
      overflow <= (raw > CAP_S);

      case (state)
        NORMAL: begin
          if (level <= LOW_ON)
            state <= LOW;
          else if (level >= HIGH_ON)
            state <= HIGH;
        end
        LOW:     if (level >= LOW_OFF)  state <= NORMAL;
        HIGH:    if (level <= HIGH_OFF) state <= NORMAL;
        default: state <= NORMAL;
      endcase

      // Clear beats a same-cycle set so the operator always regains control.
      if (fault_clr) begin
        dry_cnt   <= '0;
        dry_fault <= 1'b0;
      end else begin
        if (pump_activated && level == '0)
          dry_cnt <= (dry_cnt == DRY_LIMIT) ? dry_cnt : dry_cnt + 1'b1;
        else
          dry_cnt <= '0;
        if (dry_cnt == DRY_LIMIT)
          dry_fault <= 1'b1;
      end
    end
  end

  assign alarm_state = state;
  assign low_alarm   = (state == LOW);
  assign high_alarm  = (state == HIGH);

  level_thermo_enc #(
    .LEVEL_W  (LEVEL_W),
    .CAPACITY (CAPACITY),
    .NUM_BANDS(NUM_BANDS)
  ) u_enc (
    .level     (level),
    .sensor_out(sensor_out)
  );

endmodule

// File: tb/tb_tank_level_monitor.sv
// Directed scoreboard bench for tank_level_monitor with default parameters.
module tb_tank_level_monitor;
  import tank_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pump_activated = 1'b0;
  logic       valve_open = 1'b0;
  logic       fault_clr = 1'b0;
  logic [8:0] level;
  logic [9:0] sensor_out;
  logic [1:0] alarm_state;
  logic       low_alarm;
  logic       high_alarm;
  logic       dry_fault;
  logic       overflow;

  tank_level_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .pump_activated(pump_activated),
    .valve_open    (valve_open),
    .fault_clr     (fault_clr),
    .level         (level),
    .sensor_out    (sensor_out),
    .alarm_state   (alarm_state),
    .low_alarm     (low_alarm),
    .high_alarm    (high_alarm),
    .dry_fault     (dry_fault),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef enum {F_LEVEL, F_SENSOR, F_ALARM, F_LOW, F_FAULT, F_OVF} field_t;
  typedef struct {
    int     cyc;
    field_t f;
    int     val;
    string  name;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt  = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int sample(input field_t f);
    case (f)
      F_LEVEL:  return int'(level);
      F_SENSOR: return int'(sensor_out);
      F_ALARM:  return int'(alarm_state);
      F_LOW:    return int'(low_alarm);
      F_FAULT:  return int'(dry_fault);
      default:  return int'(overflow);
    endcase
  endfunction

  // Expectation for the state visible just after the next rising edge.
  task automatic push_exp(input field_t f, input int v, input string name);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.f    = f;
    e.val  = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic drive(input logic p, input logic v, input logic c);
    @(negedge clk);
    pump_activated = p;
    valve_open     = v;
    fault_clr      = c;
  endtask

  always @(posedge clk) begin
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc_cnt)
        check({e.name, "_missed"}, e.cyc, cyc_cnt);
      else
        check(e.name, sample(e.f), e.val);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_level", int'(level), 100);
    check("rst_sensor", int'(sensor_out), 'h3FF);
    check("rst_alarm", int'(alarm_state), 0);
    check("rst_fault", int'(dry_fault), 0);
    check("rst_ovf", int'(overflow), 0);

    @(negedge clk);
    rst = 1'b0;
    push_exp(F_LEVEL, 100, "post_rst_level");
    push_exp(F_ALARM, 2, "post_rst_alarm_high");

    // Drain 81 cycles from 100.
    for (int i = 1; i <= 81; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (i == 15) push_exp(F_ALARM, 2, "drain_still_high");
      if (i == 16) push_exp(F_ALARM, 0, "drain_normal");
      if (i == 80) begin
        push_exp(F_LEVEL, 20, "drain_level20");
        push_exp(F_SENSOR, 'h003, "drain_sensor20");
        push_exp(F_LOW, 0, "drain_low_lag");
      end
      if (i == 81) begin
        push_exp(F_LEVEL, 19, "drain_level19");
        push_exp(F_SENSOR, 'h001, "drain_sensor19");
        push_exp(F_LOW, 1, "drain_low_set");
      end
    end

    // Fill out of LOW: 21, 23, 25, 27.
    for (int j = 1; j <= 4; j++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (j == 2) push_exp(F_LOW, 1, "hyst_low_hold23");
      if (j == 3) begin
        push_exp(F_LEVEL, 25, "fill_level25");
        push_exp(F_LOW, 1, "hyst_low_hold25");
      end
      if (j == 4) push_exp(F_LOW, 0, "hyst_low_release");
    end

    // Overflow at the top.
    for (int j = 1; j <= 36; j++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (j == 36) begin
        push_exp(F_LEVEL, 99, "fill_level99");
        push_exp(F_OVF, 0, "fill99_no_ovf");
      end
    end
    drive(1'b0, 1'b1, 1'b0);
    push_exp(F_LEVEL, 100, "clamp_level100");
    push_exp(F_OVF, 1, "ovf_pulse");
    drive(1'b0, 1'b0, 1'b0);
    push_exp(F_OVF, 0, "ovf_single_cycle");
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    push_exp(F_LEVEL, 98, "level98");
    drive(1'b0, 1'b1, 1'b0);
    push_exp(F_LEVEL, 100, "fill98_level100");
    push_exp(F_OVF, 0, "fill98_no_ovf");

    // Band boundaries, then simultaneous fill and drain netting +1.
    for (int j = 1; j <= 71; j++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (j == 70) push_exp(F_SENSOR, 'h007, "sensor_at30");
      if (j == 71) push_exp(F_SENSOR, 'h003, "sensor_at29");
    end
    for (int j = 1; j <= 23; j++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (j == 21) begin
        push_exp(F_LEVEL, 50, "net_level50");
        push_exp(F_SENSOR, 'h01F, "sensor_at50");
      end
      if (j == 22) push_exp(F_LEVEL, 51, "net_level51");
      if (j == 23) push_exp(F_LEVEL, 52, "net_level52");
    end

    // Drain to empty and hold the pump dry.
    for (int j = 1; j <= 52; j++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (j == 52) begin
        push_exp(F_LEVEL, 0, "empty_level0");
        push_exp(F_SENSOR, 0, "empty_sensor");
      end
    end
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (k == 8) push_exp(F_FAULT, 0, "dry_not_yet");
      if (k == 9) push_exp(F_FAULT, 1, "dry_fault_set");
    end
    drive(1'b1, 1'b0, 1'b1);
    push_exp(F_FAULT, 0, "clr_wins");
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (k == 8) push_exp(F_FAULT, 0, "refault_not_yet");
      if (k == 9) push_exp(F_FAULT, 1, "refault_set");
    end
    drive(1'b1, 1'b1, 1'b0);
    push_exp(F_LEVEL, 2, "interlock_level2");
    drive(1'b1, 1'b1, 1'b0);
    push_exp(F_LEVEL, 4, "interlock_level4");
    push_exp(F_FAULT, 1, "fault_latched");

    // Clear, fill to 40, then reset in the middle of a drain cycle.
    drive(1'b0, 1'b1, 1'b1);
    push_exp(F_LEVEL, 6, "clr_fill_level6");
    push_exp(F_FAULT, 0, "clr_fault");
    for (int j = 1; j <= 17; j++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (j == 17) push_exp(F_LEVEL, 40, "fill_level40");
    end
    drive(1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_level", int'(level), 100);
    check("async_rst_fault", int'(dry_fault), 0);
    check("async_rst_ovf", int'(overflow), 0);
    check("async_rst_alarm", int'(alarm_state), 0);
    @(negedge clk);
    rst = 1'b0;
    pump_activated = 1'b0;
    push_exp(F_LEVEL, 100, "rerelease_level");
    push_exp(F_ALARM, 2, "rerelease_alarm_high");

    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tank_level_monitor.md
TANK_LEVEL_MONITOR -- requirements
Module: tank_level_monitor

Interface
REQ-001 Parameter LEVEL_W, default 9: level register width.
REQ-002 Parameter CAPACITY, default 100: maximum level; SHALL be < 2**LEVEL_W.
REQ-003 Parameter NUM_BANDS, default 10: sensor bands; SHALL divide CAPACITY exactly (STEP = CAPACITY/NUM_BANDS).
REQ-004 Parameter RESET_LEVEL, default 100: level loaded on reset; SHALL be <= CAPACITY.
REQ-005 Parameters FILL_RATE, default 2, and DRAIN_RATE, default 1: units per cycle added by the valve and removed by the pump.
REQ-006 Parameters LOW_TH, default 20; HIGH_TH, default 90; HYST, default 5: alarm thresholds and hysteresis.
REQ-007 Parameter DRY_CYCLES, default 8: consecutive dry-pump cycles before a fault.
REQ-008 clk  input  1  clock; all state updates on the rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-high.
REQ-010 pump_activated  input  1  drain request.
REQ-011 valve_open  input  1  fill request.
REQ-012 fault_clr  input  1  clears the latched dry fault.
REQ-013 level  output  LEVEL_W  current registered level.
REQ-014 sensor_out  output  NUM_BANDS  thermometer code of the level.
REQ-015 alarm_state  output  2  FSM state: 0 NORMAL, 1 LOW, 2 HIGH.
REQ-016 low_alarm, high_alarm  output  1 each  decoded from alarm_state.
REQ-017 dry_fault  output  1  latched pump-dry fault.
REQ-018 overflow  output  1  single-cycle pulse when a fill is clamped.

Function
REQ-019 The effective pump SHALL be pump_activated AND NOT dry_fault (interlock).
REQ-020 Each cycle: next = level + (valve_open ? FILL_RATE : 0) - (effective pump ? DRAIN_RATE : 0), computed signed in LEVEL_W+2 bits, then clamped to 0..CAPACITY.
REQ-021 Simultaneous fill and drain SHALL net in the same cycle; with the defaults, both active gives +1.
REQ-022 overflow SHALL be registered, asserted in the cycle following an update whose unclamped value exceeded CAPACITY, and low otherwise.
REQ-023 Bit k of sensor_out (k = 0..NUM_BANDS-1) SHALL be 1 iff level >= (k+1)*STEP.
REQ-024 sensor_out SHALL be combinational from level, with no gaps at exact band boundaries.
REQ-025 The FSM SHALL evaluate the registered level, so alarms lag the level by one cycle.
REQ-026 NORMAL->LOW when level <= LOW_TH; LOW->NORMAL when level >= LOW_TH+HYST.
REQ-027 NORMAL->HIGH when level >= HIGH_TH; HIGH->NORMAL when level <= HIGH_TH-HYST.
REQ-028 No direct LOW<->HIGH transition SHALL exist.
REQ-029 The dry counter SHALL increment, saturating at DRY_CYCLES, while pump_activated=1 and level=0, and SHALL clear otherwise.
REQ-030 dry_fault SHALL set on the cycle after the counter reaches DRY_CYCLES, and SHALL hold until fault_clr.
REQ-031 fault_clr SHALL clear dry_fault and the counter, and SHALL win over a same-cycle set condition.

Reset
REQ-032 On rst: level=RESET_LEVEL; alarm_state=NORMAL; dry counter=0; dry_fault=0; overflow=0.
REQ-033 Reset asserted mid-operation SHALL take effect immediately and discard in-flight updates.
REQ-034 The FSM SHALL re-evaluate on the first clock edge after reset release.

Structure
REQ-035 Shared package tank_pkg SHALL hold the alarm-state enum (NORMAL/LOW/HIGH) and the default parameter constants.
REQ-036 The thermometer encoder SHALL be a sub-module level_thermo_enc (parameters LEVEL_W, CAPACITY, NUM_BANDS).

Verification
REQ-037 Reset with defaults, idle inputs: level=100, sensor_out=10'h3FF, alarm_state=HIGH one cycle after release.
REQ-038 Pump held for 81 cycles from 100: level=19; sensor_out=10'h001; low_alarm asserted the cycle after level=20; low_alarm held until valve raises level to 25.
REQ-039 Level 99, valve_open for 1 cycle: level=100 and overflow pulses exactly one cycle; level 98 with valve gives 100 and no overflow.
REQ-040 Level 0, pump held: dry_fault=1 after 8 dry cycles; valve+pump then yields +2/cycle; fault_clr with pump still held: dry_fault=0 that cycle, then re-fault after 8 more cycles.
REQ-041 Boundary sweep: level 30 gives 10'h007 and level 29 gives 10'h003; valve+pump both active from level 50 gives 51, 52, ...
REQ-042 rst asserted mid-drain at level 40: level=100 asynchronously, dry_fault/overflow=0.
